// File: rtl/block_pkg.sv
// Shared definitions for the block-structure stream generator.
// Holds token encodings, FSM states, keyword identifiers, ASCII constants and keyword lengths.
// Pure declarations: no logic, no latency, no flow control of its own.
package block_pkg;

    // Token encodings on tok_type
    localparam logic [1:0] TOK_SPACE = 2'b00;
    localparam logic [1:0] TOK_BEGIN = 2'b01;
    localparam logic [1:0] TOK_END   = 2'b10;
    localparam logic [1:0] TOK_WORD  = 2'b11;

    // Serialiser states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_KEY   = 3'd2,
        ST_TRAIL = 3'd3,
        ST_CHAR  = 3'd4
    } state_t;

    // Which keyword is being spelled out
    typedef enum logic {
        KW_BEGIN = 1'b0,
        KW_END   = 1'b1
    } kw_t;

    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam logic [2:0] KW_BEGIN_LEN = 3'd5;
    localparam logic [2:0] KW_END_LEN   = 3'd3;

    // Index of the final character of a keyword
    function automatic logic [2:0] kw_last(input kw_t kw);
        return (kw == KW_END) ? (KW_END_LEN - 3'd1) : (KW_BEGIN_LEN - 3'd1);
    endfunction

endpackage

// File: rtl/block_kw_rom.sv
// Keyword character lookup: (keyword, index) -> ASCII character.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the character is used.
// Ports: kw selects "begin"/"end", idx is the character position, ch is the ASCII result.
// Build option: BLOCK_GEN_UPPER_EN selects uppercase keyword letters.
module block_kw_rom
    import block_pkg::*;
(
    input  kw_t        kw,
    input  logic [2:0] idx,
    output logic [7:0] ch
);

    logic [7:0] lc;

    // Out-of-range indices fall back to a space so a stray lookup is harmless.
    always_comb begin
        lc = CH_SPACE;
        if (kw == KW_BEGIN) begin
            case (idx)
                3'd0:    lc = 8'h62; // b
                3'd1:    lc = 8'h65; // e
                3'd2:    lc = 8'h67; // g
                3'd3:    lc = 8'h69; // i
                3'd4:    lc = 8'h6e; // n
                default: lc = CH_SPACE;
            endcase
        end else begin
            case (idx)
                3'd0:    lc = 8'h65; // e
                3'd1:    lc = 8'h6e; // n
                3'd2:    lc = 8'h64; // d
                default: lc = CH_SPACE;
            endcase
        end
    end

`ifdef BLOCK_GEN_UPPER_EN
    // Lowercase to uppercase is a fixed offset for ASCII letters; leave the space alone.
    assign ch = (lc == CH_SPACE) ? lc : (lc - 8'h20);
`else
    assign ch = lc;
`endif

endmodule

// File: rtl/block_stream_gen.sv
// Serialises BEGIN/END/SPACE/WORD tokens into a delimited ASCII stream and tracks nesting depth.
// Latency: first character valid the cycle after token acceptance; one idle cycle between tokens.
// Backpressure: out_char/out_valid hold while out_ready is low; tok_ready is high only when idle.
// Ports: clk/reset (async active-low); tok_valid/tok_ready/tok_type/tok_char token input;
//        out_valid/out_ready/out_char character output; depth/balanced/err status.
// Build option: BLOCK_GEN_UPPER_EN emits keywords in uppercase (handled in block_kw_rom).
module block_stream_gen
    import block_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tok_valid,
    output logic               tok_ready,
    input  logic [1:0]         tok_type,
    input  logic [7:0]         tok_char,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_char,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               err
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    state_t     state;
    kw_t        kw_sel;
    logic [2:0] idx;
    logic       last_sp;

    logic       consume;
    logic       is_kw_tok;
    kw_t        rom_kw;
    logic [2:0] rom_idx;
    logic [7:0] rom_ch;

    assign consume   = out_valid && out_ready;
    assign tok_ready = (state == ST_IDLE);
    assign balanced  = (depth == '0) && !err;
    assign is_kw_tok = (tok_type == TOK_BEGIN) || (tok_type == TOK_END);

    // One ROM serves both lookups: in IDLE it provides the first keyword
    // character straight from the incoming token, elsewhere it looks ahead to
    // the character that follows the one currently on out_char.
    assign rom_kw  = (state == ST_IDLE) ? ((tok_type == TOK_END) ? KW_END : KW_BEGIN) : kw_sel;
    assign rom_idx = (state == ST_KEY) ? (idx + 3'd1) : 3'd0;

    block_kw_rom u_kw_rom (
        .kw  (rom_kw),
        .idx (rom_idx),
        .ch  (rom_ch)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            kw_sel    <= KW_BEGIN;
            idx       <= 3'd0;
            last_sp   <= 1'b1;
            out_valid <= 1'b0;
            out_char  <= CH_SPACE;
            depth     <= '0;
            err       <= 1'b0;
        end else begin
            // Track whether the last character that actually left was a space,
            // so a keyword never fuses with a preceding WORD character.
            if (consume) begin
                last_sp <= (out_char == CH_SPACE);
            end

            case (state)
                ST_IDLE: begin
                    if (tok_valid) begin
                        out_valid <= 1'b1;
                        if (is_kw_tok) begin
                            kw_sel <= rom_kw;
                            idx    <= 3'd0;
                            if (last_sp) begin
                                state    <= ST_KEY;
                                out_char <= rom_ch;
                            end else begin
                                state    <= ST_LEAD;
                                out_char <= CH_SPACE;
                            end
                            // Over/underflow sets the sticky error but the
                            // keyword is still emitted for the downstream checker.
                            if (tok_type == TOK_BEGIN) begin
                                if (depth == DEPTH_MAX) begin
                                    err <= 1'b1;
                                end else begin
                                    depth <= depth + 1'b1;
                                end
                            end else begin
                                if (depth == '0) begin
                                    err <= 1'b1;
                                end else begin
                                    depth <= depth - 1'b1;
                                end
                            end
                        end else begin
                            state    <= ST_CHAR;
                            out_char <= (tok_type == TOK_WORD) ? tok_char : CH_SPACE;
                        end
                    end
                end

                ST_LEAD: begin
                    if (consume) begin
                        state    <= ST_KEY;
                        idx      <= 3'd0;
                        out_char <= rom_ch;
                    end
                end

                ST_KEY: begin
                    if (consume) begin
                        if (idx == kw_last(kw_sel)) begin
                            state    <= ST_TRAIL;
                            out_char <= CH_SPACE;
                        end else begin
                            idx      <= idx + 3'd1;
                            out_char <= rom_ch;
                        end
                    end
                end

                ST_TRAIL, ST_CHAR: begin
                    if (consume) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_stream_gen.sv
// Self-checking bench for block_stream_gen with a character scoreboard.
// Expected characters are queued when a token is offered and popped as the DUT emits them.
// Output backpressure is either held high or toggled 1,0,0 to exercise stalls.
module tb_block_stream_gen;
    import block_pkg::*;

    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tok_valid = 1'b0;
    logic          tok_ready;
    logic [1:0]    tok_type = 2'b00;
    logic [7:0]    tok_char = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_char;
    logic [DW-1:0] depth;
    logic          balanced;
    logic          err;

    always #5 clk = ~clk;

    block_stream_gen #(.DEPTH_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_type  (tok_type),
        .tok_char  (tok_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .depth     (depth),
        .balanced  (balanced),
        .err       (err)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         m_depth = 0;
    bit         m_err = 1'b0;
    bit         m_last_sp = 1'b1;
    bit         toggle_mode = 1'b0;
    bit         held_vld = 1'b0;
    logic [7:0] held_ch = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected characters and depth/err for one token.
    task automatic push_kw(input bit is_end);
        string s;
        s = is_end ? "end" : "begin";
        if (!m_last_sp) exp_q.push_back(8'h20);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
`ifdef BLOCK_GEN_UPPER_EN
            c = c - 8'h20;
`endif
            exp_q.push_back(c);
        end
        exp_q.push_back(8'h20);
        m_last_sp = 1'b1;
    endtask

    task automatic model_tok(input logic [1:0] t, input logic [7:0] c);
        case (t)
            TOK_SPACE: begin exp_q.push_back(8'h20); m_last_sp = 1'b1; end
            TOK_WORD:  begin exp_q.push_back(c); m_last_sp = (c == 8'h20); end
            TOK_BEGIN: begin
                push_kw(1'b0);
                if (m_depth == (1 << DW) - 1) m_err = 1'b1; else m_depth++;
            end
            default: begin
                push_kw(1'b1);
                if (m_depth == 0) m_err = 1'b1; else m_depth--;
            end
        endcase
    endtask

    // Offer a token and return once it has been accepted.
    task automatic send(input logic [1:0] t, input logic [7:0] c);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        tok_valid = 1'b1;
        tok_type  = t;
        tok_char  = c;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tok_ready) begin ok = 1'b1; break; end
        end
        if (ok) begin
            model_tok(t, c);
        end else begin
            check("tok_ready_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check({tag, "_drain"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_depth"}, depth, m_depth);
        check({tag, "_err"}, err, m_err);
        check({tag, "_balanced"}, balanced, (m_depth == 0) && !m_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_depth = 0;
        m_err = 1'b0;
        m_last_sp = 1'b1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Output backpressure driver
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) begin
                out_ready = (ph % 3 == 0);
                ph++;
            end else begin
                out_ready = 1'b1;
                ph = 0;
            end
        end
    end

    // Output monitor: scoreboard pop, stall stability, tok_ready busy
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                held_vld = 1'b0;
            end else begin
                if (out_valid) begin
                    check("tok_ready_busy", tok_ready, 32'd0);
                    if (held_vld) check("stall_hold", out_char, held_ch);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_char", out_char, 32'hffff_ffff);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("char", out_char, e);
                    end
                    held_vld = 1'b0;
                end else if (out_valid) begin
                    held_vld = 1'b1;
                    held_ch  = out_char;
                end else begin
                    held_vld = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_char", out_char, 32'h20);
        check("rst_depth", depth, 32'd0);
        check("rst_err", err, 32'd0);
        check("rst_balanced", balanced, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_tok_ready", tok_ready, 32'd1);

        // "begin end "
        send(TOK_BEGIN, 8'h00);
        drain("t1a");
        check_status("t1a");
        send(TOK_END, 8'h00);
        drain("t1b");
        check_status("t1b");

        // "a begin " then "x begin " via explicit SPACE, then close both
        send(TOK_WORD, 8'h61);
        send(TOK_BEGIN, 8'h00);
        drain("t2a");
        check_status("t2a");
        send(TOK_WORD, 8'h78);
        send(TOK_SPACE, 8'h00);
        send(TOK_BEGIN, 8'h00);
        send(TOK_END, 8'h00);
        send(TOK_END, 8'h00);
        drain("t2b");
        check_status("t2b");

        // END underflow, error is sticky
        do_reset();
        send(TOK_END, 8'h00);
        drain("t3a");
        check_status("t3a");
        send(TOK_BEGIN, 8'h00);
        send(TOK_END, 8'h00);
        drain("t3b");
        check_status("t3b");

        // Stalled output
        do_reset();
        toggle_mode = 1'b1;
        send(TOK_BEGIN, 8'h00);
        drain("t4a");
        send(TOK_WORD, 8'h7a);
        send(TOK_END, 8'h00);
        drain("t4b");
        toggle_mode = 1'b0;
        check_status("t4b");

        // Depth saturation at 3
        do_reset();
        for (int i = 0; i < 3; i++) send(TOK_BEGIN, 8'h00);
        drain("t5a");
        check_status("t5a");
        send(TOK_BEGIN, 8'h00);
        drain("t5b");
        check_status("t5b");

        // Reset in the middle of a keyword, after a WORD forced a leading space
        do_reset();
        send(TOK_WORD, 8'h78);
        drain("t6a");
        send(TOK_BEGIN, 8'h00);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() <= 4) break;
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        exp_q.delete();
        m_depth = 0;
        m_err = 1'b0;
        m_last_sp = 1'b1;
        #1;
        check("t6_rst_out_valid", out_valid, 32'd0);
        check("t6_rst_depth", depth, 32'd0);
        check("t6_rst_err", err, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send(TOK_BEGIN, 8'h00);
        drain("t6b");
        check_status("t6b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/block_stream_gen.md
Name: block_stream_gen

Overview:
- Transmit-side counterpart of the block-structure checker.
- Accepts abstract tokens (BEGIN, END, SPACE, WORD-char) over a valid/ready handshake.
- Serialises them into the ASCII character stream that the checker consumes: one character per accepted output beat.
- Inserts word delimiters automatically and tracks nesting depth so the producer knows whether the emitted stream is balanced.

Parameters:
- DEPTH_W, 8, width of the nesting-depth counter; depth saturates at 2^DEPTH_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- tok_valid  in  1  token offered.
- tok_ready  out  1  block can accept a token this cycle.
- tok_type  in  2  00 SPACE, 01 BEGIN, 10 END, 11 WORD.
- tok_char  in  8  character to emit for WORD; ignored otherwise.
- out_valid  out  1  out_char holds a valid character.
- out_ready  in  1  downstream accepts out_char this cycle.
- out_char  out  8  emitted ASCII character.
- depth  out  DEPTH_W  current nesting depth, counting accepted tokens.
- balanced  out  1  depth==0 && !err.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values (asynchronous, reset==0):
  - state=IDLE, out_valid=0, out_char=8'h20, depth=0, err=0, last_sp=1.
  - tok_ready=1 after reset release.
- Token handshake:
  - tok_ready = (state==IDLE).
  - A token is accepted on a rising edge with tok_valid && tok_ready.
- Output handshake:
  - out_char and out_valid are registered.
  - A character is consumed on an edge with out_valid && out_ready.
  - out_char must hold stable while out_valid && !out_ready.
- States:
  - IDLE: waiting for a token.
  - LEAD: emitting a leading space.
  - KEY: emitting keyword characters; idx counts 0..4 for "begin", 0..2 for "end".
  - TRAIL: emitting a trailing space.
  - CHAR: emitting a WORD character or a SPACE token.
- Transitions:
  - IDLE, on accept:
    - BEGIN/END with last_sp==0 -> LEAD.
    - BEGIN/END with last_sp==1 -> KEY, idx=0.
    - WORD -> CHAR, out_char=tok_char.
    - SPACE -> CHAR, out_char=8'h20.
  - LEAD, on consume -> KEY, idx=0.
  - KEY, on consume:
    - If idx==last -> TRAIL.
    - Else idx+1.
  - TRAIL, on consume -> IDLE.
  - CHAR, on consume -> IDLE.
- Latency:
  - The first character is valid in the cycle after acceptance.
  - With out_ready held at 1, BEGIN emitted after a space occupies 6 beats ("begin "), then tok_ready returns.
  - There is one idle cycle between tokens (tok_ready is asserted only in IDLE).
- last_sp:
  - Updated on each consumed character: 1 if the character is 8'h20, else 0.
  - Keeps keywords delimited from adjacent WORD characters.
- Depth and error, updated at token acceptance:
  - BEGIN: depth+1; at max, depth holds and err is set.
  - END: depth-1; at 0, depth stays 0 and err is set.
  - The END characters are still emitted so that the downstream checker also flags the error.
- err is sticky until reset.
- Keywords are emitted in lowercase by default.
- Reset mid-emission aborts the current token: out_valid drops asynchronously.

Optional Feature:
- Macro: BLOCK_GEN_UPPER_EN.
- Defined: keyword characters are emitted in uppercase ("BEGIN", "END"); WORD/SPACE characters are unchanged.
- Undefined: keyword characters are emitted in lowercase.
- Depth and err behaviour is identical in both builds.

Decomposition:
- Shared package block_pkg holds:
  - Token encodings TOK_SPACE/TOK_BEGIN/TOK_END/TOK_WORD.
  - State encodings.
  - ASCII constants CH_SPACE=8'h20.
  - Keyword lengths (5, 3).
- One sub-module, block_kw_rom, is natural: combinational keyword + idx -> character, honouring BLOCK_GEN_UPPER_EN.

Test Plan:
- Reset, then BEGIN, END with out_ready=1 -> stream "begin end ", depth 1 then 0, balanced=1, err=0.
- WORD 'a' then BEGIN -> stream "a begin ": leading space inserted; depth=1, balanced=0.
- END immediately after reset -> stream "end ", depth stays 0, err=1, balanced=0; subsequent BEGIN/END leaves err=1.
- BEGIN with out_ready toggling 1,0,0,1,... -> out_char holds its value through stall cycles; the exact sequence "begin " is still produced, and tok_ready stays 0 until the trailing space is consumed.
- DEPTH_W=2: four BEGINs -> depth saturates at 3, err=1 on the fourth.
- Assert reset=0 mid-"begin" -> out_valid=0, depth=0, err=0 immediately; after release the first token produces a fresh stream with no leading space.
